// File: rtl/unidade_despacho_param_if.sv
// Issue-stage bundle: instruction queue handshake, register status/data view,
// CDB snoop, and the registered issue/rename strobes toward the RS array.
interface unidade_despacho_param_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RS   = 2,
  parameter int TAG_W    = 3
);
  logic                         Instr_Valid;
  logic [15:0]                  Instr;
  logic                         Instr_Ready;
  logic [NUM_REGS*TAG_W-1:0]    Reg_Qi;
  logic [NUM_REGS*DATA_W-1:0]   Reg_Data;
  logic [NUM_RS-1:0]            RS_Busy;
  logic                         Cdb_Valid;
  logic [TAG_W-1:0]             Cdb_Tag;
  logic [DATA_W-1:0]            Cdb_Data;
  logic                         Issue_Valid;
  logic [NUM_RS-1:0]            RS_Enable;
  logic [2:0]                   Opcode;
  logic [TAG_W-1:0]             Dest_Tag;
  logic [DATA_W-1:0]            Vj;
  logic [DATA_W-1:0]            Vk;
  logic [TAG_W-1:0]             Qj;
  logic [TAG_W-1:0]             Qk;
  logic                         Rt_Write_En;
  logic [2:0]                   Rt_Write_Reg;
  logic [TAG_W-1:0]             Rt_Write_Tag;
  logic [15:0]                  Stall_Count;

  // master: the dispatcher itself; slave: queue, register table and RS array
  modport master (
    input  Instr_Valid, Instr, Reg_Qi, Reg_Data, RS_Busy, Cdb_Valid, Cdb_Tag, Cdb_Data,
    output Instr_Ready, Issue_Valid, RS_Enable, Opcode, Dest_Tag, Vj, Vk, Qj, Qk,
           Rt_Write_En, Rt_Write_Reg, Rt_Write_Tag, Stall_Count
  );

  modport slave (
    output Instr_Valid, Instr, Reg_Qi, Reg_Data, RS_Busy, Cdb_Valid, Cdb_Tag, Cdb_Data,
    input  Instr_Ready, Issue_Valid, RS_Enable, Opcode, Dest_Tag, Vj, Vk, Qj, Qk,
           Rt_Write_En, Rt_Write_Reg, Rt_Write_Tag, Stall_Count
  );
endinterface

// File: rtl/unidade_despacho_param.sv
// Tomasulo issue stage: picks lowest free RS, resolves operands (CDB bypass), renames Ri.
// One-cycle issue latency; Instr_Ready is combinational and drops while no station is free.
module unidade_despacho_param #(
  parameter int          DATA_W     = 16,
  parameter int          NUM_REGS   = 8,
  parameter int          NUM_RS     = 2,
  parameter int          TAG_W      = 3,
  parameter logic [2:0]  NOP_OPCODE = 3'b000,
  parameter logic [15:0] VAL_NONE   = 16'hFFF0
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  unidade_despacho_param_if.master    disp
);

  localparam logic [DATA_W-1:0] NONE_V = DATA_W'(VAL_NONE);

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } opnd_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [NUM_RS-1:0]   pending;
  logic [NUM_RS-1:0]   avail;
  logic [NUM_RS-1:0]   grant;
  logic [TAG_W-1:0]    grant_tag;
  logic [2:0]          op, ri, rj, rk;
  logic                is_nop, accept, issue, stall_inc;
  logic [TAG_W-1:0]    qi_j, qi_k;
  logic [DATA_W-1:0]   rd_j, rd_k;
  opnd_t               opnd_j, opnd_k;
  logic                unused_instr_bits;

  assign op = disp.Instr[15:13];
  assign ri = disp.Instr[12:10];
  assign rj = disp.Instr[9:7];
  assign rk = disp.Instr[6:4];
  assign unused_instr_bits = ^disp.Instr[3:0];

  // A station loaded last cycle is not yet reflected in RS_Busy, so mask it here.
  assign avail  = ~disp.RS_Busy & ~pending;
  assign is_nop = (op == NOP_OPCODE);
  assign disp.Instr_Ready = is_nop | (|avail);
  assign accept = disp.Instr_Valid & disp.Instr_Ready;
  assign issue  = accept & ~is_nop;

  always_comb begin
    grant     = '0;
    grant_tag = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_tag = TAG_W'(i + 1);
      end
    end
  end

  always_comb begin
    qi_j = '0;
    rd_j = '0;
    qi_k = '0;
    rd_k = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rj == 3'(r)) begin
        qi_j = disp.Reg_Qi[r*TAG_W +: TAG_W];
        rd_j = disp.Reg_Data[r*DATA_W +: DATA_W];
      end
      if (rk == 3'(r)) begin
        qi_k = disp.Reg_Qi[r*TAG_W +: TAG_W];
        rd_k = disp.Reg_Data[r*DATA_W +: DATA_W];
      end
    end
  end

  function automatic opnd_t resolve(
    input logic [TAG_W-1:0]  qi,
    input logic [DATA_W-1:0] rd,
    input logic              cdb_vld,
    input logic [TAG_W-1:0]  cdb_tag,
    input logic [DATA_W-1:0] cdb_dat
  );
    opnd_t o;
    if (qi == '0) begin
      o.v = rd;
      o.q = '0;
    end else if (cdb_vld && (qi == cdb_tag)) begin
      o.v = cdb_dat;
      o.q = '0;
    end else begin
      o.v = NONE_V;
      o.q = qi;
    end
    return o;
  endfunction

  // Sources use the pre-rename status, so Ri==Rj/Rk never self-references.
  assign opnd_j = resolve(qi_j, rd_j, disp.Cdb_Valid, disp.Cdb_Tag, disp.Cdb_Data);
  assign opnd_k = resolve(qi_k, rd_k, disp.Cdb_Valid, disp.Cdb_Tag, disp.Cdb_Data);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (disp.Instr_Valid && !disp.Instr_Ready) state_nxt = STALL;
      STALL:   if (!disp.Instr_Valid || disp.Instr_Ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_inc = 1'b0;
    case (state)
      RUN:     stall_inc = disp.Instr_Valid & ~disp.Instr_Ready;
      STALL:   stall_inc = disp.Instr_Valid & ~disp.Instr_Ready;
      default: stall_inc = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pending           <= '0;
      disp.Issue_Valid  <= 1'b0;
      disp.RS_Enable    <= '0;
      disp.Opcode       <= 3'b000;
      disp.Dest_Tag     <= '0;
      disp.Vj           <= NONE_V;
      disp.Vk           <= NONE_V;
      disp.Qj           <= '0;
      disp.Qk           <= '0;
      disp.Rt_Write_En  <= 1'b0;
      disp.Rt_Write_Reg <= 3'b000;
      disp.Rt_Write_Tag <= '0;
      disp.Stall_Count  <= 16'h0000;
    end else begin
      pending          <= issue ? grant : '0;
      disp.Issue_Valid <= issue;
      disp.RS_Enable   <= issue ? grant : '0;
      disp.Rt_Write_En <= issue;
      if (issue) begin
        disp.Opcode       <= op;
        disp.Dest_Tag     <= grant_tag;
        disp.Vj           <= opnd_j.v;
        disp.Qj           <= opnd_j.q;
        disp.Vk           <= opnd_k.v;
        disp.Qk           <= opnd_k.q;
        disp.Rt_Write_Reg <= ri;
        disp.Rt_Write_Tag <= grant_tag;
      end
      if (stall_inc && (disp.Stall_Count != 16'hFFFF))
        disp.Stall_Count <= disp.Stall_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_unidade_despacho_param.sv
// Directed bench for the parametrised issue stage (NUM_RS=2, default widths).
module tb_unidade_despacho_param;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int NUM_RS   = 2;
  localparam int TAG_W    = 3;

  logic Clock;
  logic Reset_n;
  int   tests;
  int   failed;

  unidade_despacho_param_if #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RS(NUM_RS), .TAG_W(TAG_W)
  ) u_if ();

  unidade_despacho_param #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RS(NUM_RS), .TAG_W(TAG_W),
    .NOP_OPCODE(3'b000), .VAL_NONE(16'hFFF0)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .disp   (u_if.master)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] ri,
                                      input logic [2:0] rj, input logic [2:0] rk);
    return {op, ri, rj, rk, 4'b0000};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    u_if.Instr_Valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_strobes got %b expected 0000", {u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En});
    end
    tests++;
    if ({u_if.Vj, u_if.Vk} !== {16'hFFF0, 16'hFFF0}) begin
      failed++;
      $display("FAIL reset_v got %h/%h expected fff0/fff0", u_if.Vj, u_if.Vk);
    end
    tests++;
    if ({u_if.Opcode, u_if.Dest_Tag, u_if.Qj, u_if.Qk, u_if.Rt_Write_Reg, u_if.Rt_Write_Tag} !== 18'd0) begin
      failed++;
      $display("FAIL reset_fields got %h expected 0", {u_if.Opcode, u_if.Dest_Tag, u_if.Qj, u_if.Qk, u_if.Rt_Write_Reg, u_if.Rt_Write_Tag});
    end
    tests++;
    if (u_if.Stall_Count !== 16'd0) begin
      failed++;
      $display("FAIL reset_stall got %0d expected 0", u_if.Stall_Count);
    end
  endtask

  task automatic test_basic_issue();
    u_if.Reg_Data[2*DATA_W +: DATA_W] = 16'd5;
    u_if.Reg_Data[3*DATA_W +: DATA_W] = 16'd7;
    u_if.Instr       = enc(3'b001, 3'd1, 3'd2, 3'd3);
    u_if.Instr_Valid = 1'b1;
    #1;
    tests++;
    if (u_if.Instr_Ready !== 1'b1) begin
      failed++;
      $display("FAIL basic_ready got %b expected 1", u_if.Instr_Ready);
    end
    tick();
    u_if.Instr_Valid = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Opcode} !== {1'b1, 2'b01, 3'd1, 3'b001}) begin
      failed++;
      $display("FAIL basic_issue got %b expected 1_01_001_001", {u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Opcode});
    end
    tests++;
    if ({u_if.Vj, u_if.Vk, u_if.Qj, u_if.Qk} !== {16'd5, 16'd7, 3'd0, 3'd0}) begin
      failed++;
      $display("FAIL basic_operands got %h %h %0d %0d expected 5 7 0 0", u_if.Vj, u_if.Vk, u_if.Qj, u_if.Qk);
    end
    tests++;
    if ({u_if.Rt_Write_En, u_if.Rt_Write_Reg, u_if.Rt_Write_Tag} !== {1'b1, 3'd1, 3'd1}) begin
      failed++;
      $display("FAIL basic_rename got %b expected 1_001_001", {u_if.Rt_Write_En, u_if.Rt_Write_Reg, u_if.Rt_Write_Tag});
    end
    tick();
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En, u_if.Vj} !== {4'b0000, 16'd5}) begin
      failed++;
      $display("FAIL basic_pulse_hold got %h expected 00005", {u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En, u_if.Vj});
    end
  endtask

  task automatic test_cdb_bypass();
    u_if.Reg_Qi[2*TAG_W +: TAG_W] = 3'd1;
    u_if.Cdb_Valid   = 1'b1;
    u_if.Cdb_Tag     = 3'd1;
    u_if.Cdb_Data    = 16'h0042;
    u_if.Instr       = enc(3'b010, 3'd4, 3'd2, 3'd3);
    u_if.Instr_Valid = 1'b1;
    tick();
    u_if.Instr_Valid = 1'b0;
    u_if.Cdb_Valid   = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.Vj, u_if.Qj, u_if.Vk} !== {1'b1, 16'h0042, 3'd0, 16'd7}) begin
      failed++;
      $display("FAIL cdb_hit got v=%h q=%0d vk=%h expected 0042 0 0007", u_if.Vj, u_if.Qj, u_if.Vk);
    end
    tick();
    u_if.Cdb_Valid   = 1'b1;
    u_if.Cdb_Tag     = 3'd2;
    u_if.Instr_Valid = 1'b1;
    tick();
    u_if.Instr_Valid = 1'b0;
    u_if.Cdb_Valid   = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.Vj, u_if.Qj} !== {1'b1, 16'hFFF0, 3'd1}) begin
      failed++;
      $display("FAIL cdb_miss got v=%h q=%0d expected fff0 1", u_if.Vj, u_if.Qj);
    end
    tick();
    // Ri==Rj==Rk with R2 pending on tag 2: both operands wait, new tag differs.
    u_if.Reg_Qi[2*TAG_W +: TAG_W] = 3'd2;
    u_if.Instr       = enc(3'b011, 3'd2, 3'd2, 3'd2);
    u_if.Instr_Valid = 1'b1;
    tick();
    u_if.Instr_Valid = 1'b0;
    tests++;
    if ({u_if.Vj, u_if.Vk, u_if.Qj, u_if.Qk, u_if.Dest_Tag, u_if.Rt_Write_Reg} !==
        {16'hFFF0, 16'hFFF0, 3'd2, 3'd2, 3'd1, 3'd2}) begin
      failed++;
      $display("FAIL same_src got %h %h %0d %0d tag %0d reg %0d expected fff0 fff0 2 2 tag 1 reg 2",
               u_if.Vj, u_if.Vk, u_if.Qj, u_if.Qk, u_if.Dest_Tag, u_if.Rt_Write_Reg);
    end
    u_if.Reg_Qi = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    u_if.RS_Busy     = 2'b00;
    u_if.Instr       = enc(3'b001, 3'd5, 3'd2, 3'd3);
    u_if.Instr_Valid = 1'b1;
    tick();
    u_if.Instr = enc(3'b100, 3'd6, 3'd3, 3'd2);
    #1;
    tests++;
    if ({u_if.RS_Enable, u_if.Dest_Tag, u_if.Instr_Ready} !== {2'b01, 3'd1, 1'b1}) begin
      failed++;
      $display("FAIL b2b_first got %b expected 01_001_1", {u_if.RS_Enable, u_if.Dest_Tag, u_if.Instr_Ready});
    end
    tick();
    u_if.Instr_Valid = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Rt_Write_Reg, u_if.Vj} !==
        {1'b1, 2'b10, 3'd2, 3'd6, 16'd7}) begin
      failed++;
      $display("FAIL b2b_second got %b expected 1_10_010_110 vj=7", {u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Rt_Write_Reg, u_if.Vj});
    end
    tick();
  endtask

  task automatic test_stall();
    u_if.RS_Busy     = 2'b11;
    u_if.Instr       = enc(3'b001, 3'd1, 3'd2, 3'd3);
    u_if.Instr_Valid = 1'b1;
    #1;
    tests++;
    if (u_if.Instr_Ready !== 1'b0) begin
      failed++;
      $display("FAIL stall_ready got %b expected 0", u_if.Instr_Ready);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En} !== 4'b0000) begin
        failed++;
        $display("FAIL stall_pulse cycle %0d got %b expected 0000", c, {u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En});
      end
    end
    tests++;
    if ({u_if.Stall_Count, 1'(dut.state)} !== {16'd5, 1'b1}) begin
      failed++;
      $display("FAIL stall_count got %0d state %0d expected 5 state 1", u_if.Stall_Count, dut.state);
    end
    u_if.RS_Busy = 2'b10;
    #1;
    tests++;
    if (u_if.Instr_Ready !== 1'b1) begin
      failed++;
      $display("FAIL stall_release_ready got %b expected 1", u_if.Instr_Ready);
    end
    tick();
    u_if.Instr_Valid = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Stall_Count, 1'(dut.state)} !==
        {1'b1, 2'b01, 3'd1, 16'd5, 1'b0}) begin
      failed++;
      $display("FAIL stall_release got iv=%b en=%b tag=%0d cnt=%0d st=%0d expected 1 01 1 5 0",
               u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Stall_Count, dut.state);
    end
  endtask

  task automatic test_nop();
    u_if.RS_Busy     = 2'b11;
    u_if.Instr       = enc(3'b000, 3'd3, 3'd1, 3'd1);
    u_if.Instr_Valid = 1'b1;
    #1;
    tests++;
    if (u_if.Instr_Ready !== 1'b1) begin
      failed++;
      $display("FAIL nop_ready got %b expected 1", u_if.Instr_Ready);
    end
    tick();
    u_if.Instr_Valid = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En, u_if.Stall_Count} !== {4'b0000, 16'd5}) begin
      failed++;
      $display("FAIL nop_quiet got %b cnt=%0d expected 0000 cnt=5", {u_if.Issue_Valid, u_if.RS_Enable, u_if.Rt_Write_En}, u_if.Stall_Count);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    u_if.RS_Busy     = 2'b11;
    u_if.Instr       = enc(3'b001, 3'd1, 3'd2, 3'd3);
    u_if.Instr_Valid = 1'b1;
    repeat (3) tick();
    tests++;
    if (u_if.Stall_Count !== 16'd8) begin
      failed++;
      $display("FAIL midstall_count got %0d expected 8", u_if.Stall_Count);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    test_reset();
    tests++;
    if (1'(dut.state) !== 1'b0) begin
      failed++;
      $display("FAIL midstall_state got %0d expected 0", dut.state);
    end
    tick();
    Reset_n      = 1'b0;
    u_if.RS_Busy = 2'b00;
    tick();
    Reset_n = 1'b1;
    tick();
    u_if.Instr_Valid = 1'b0;
    tests++;
    if ({u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag, u_if.Vj} !== {1'b1, 2'b01, 3'd1, 16'd5}) begin
      failed++;
      $display("FAIL represent got %b vj=%h expected 1_01_001 vj=0005", {u_if.Issue_Valid, u_if.RS_Enable, u_if.Dest_Tag}, u_if.Vj);
    end
  endtask

  initial begin
    tests            = 0;
    failed           = 0;
    Reset_n          = 1'b0;
    u_if.Instr_Valid = 1'b0;
    u_if.Instr       = '0;
    u_if.Reg_Qi      = '0;
    u_if.Reg_Data    = '0;
    u_if.RS_Busy     = '0;
    u_if.Cdb_Valid   = 1'b0;
    u_if.Cdb_Tag     = '0;
    u_if.Cdb_Data    = '0;
    tick();
    tick();
    test_reset();
    Reset_n = 1'b1;
    tick();
    test_basic_issue();
    test_cdb_bypass();
    test_back_to_back();
    test_stall();
    test_nop();
    test_reset_mid_stall();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
